mod_step_counter: RTL

- Parametrised up/down counter for the board-level lab designs; successor to the fixed 3-bit loadable counter.
- Adds:
  - configurable width and modulus
  - direction control
  - wrap or saturate mode
  - synchronised, edge-detected push-button step input
  - terminal-count pulse and sticky boundary flag
- Feeds LED outputs directly. Optionally drives a 7-segment digit.

---
 rtl/mod_step_counter_if.sv | 28 ++
 rtl/mod_step_counter.sv | 102 ++++++++++
 2 files changed

// File: rtl/mod_step_counter_if.sv
// Signal bundle for mod_step_counter: control/step inputs and count outputs.
// MOD_STEP_COUNTER_HEX_EN adds the active-low 7-segment HEX output.
interface mod_step_counter_if #(
    parameter int WIDTH = 3
);
    logic             EN;
    logic             STEP;
    logic             LE;
    logic             DIR;
    logic             SAT;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             TC;
    logic             OVF;
`ifdef MOD_STEP_COUNTER_HEX_EN
    logic [6:0]       HEX;

    modport master (output EN, STEP, LE, DIR, SAT, D,
                    input  Q, TC, OVF, HEX);
    modport slave  (input  EN, STEP, LE, DIR, SAT, D,
                    output Q, TC, OVF, HEX);
`else
    modport master (output EN, STEP, LE, DIR, SAT, D,
                    input  Q, TC, OVF);
    modport slave  (input  EN, STEP, LE, DIR, SAT, D,
                    output Q, TC, OVF);
`endif
endinterface

// File: rtl/mod_step_counter.sv
// Parametrised up/down step counter with synchronised push-button input,
// wrap/saturate boundary handling, terminal-count pulse and sticky flag.
// Optional feature macro: MOD_STEP_COUNTER_HEX_EN (7-segment HEX decode of Q).
module mod_step_counter #(
    parameter int WIDTH = 3,
    parameter int MAX   = 7
) (
    input  logic                  CLK,
    input  logic                  RST,
    mod_step_counter_if.slave     bus
);
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX);

    logic             s1;
    logic             s2;
    logic             p;
    logic             step_pulse;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             ovf;
    logic             at_bound;

    assign step_pulse = s2 & ~p;
    // Boundary depends on direction: MAX when counting up, 0 when counting down.
    assign at_bound   = bus.DIR ? (q == MAX_Q) : (q == '0);

    // Synchroniser, edge detect and counter state; RST > LE > step > hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            p   <= 1'b0;
            q   <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            s1 <= bus.STEP;
            s2 <= s1;
            p  <= s2;
            if (bus.LE) begin
                q   <= (bus.D > MAX_Q) ? MAX_Q : bus.D;
                tc  <= 1'b0;
                ovf <= 1'b0;
            end else if (step_pulse && bus.EN) begin
                if (at_bound) begin
                    tc  <= 1'b1;
                    ovf <= 1'b1;
                    if (!bus.SAT) begin
                        q <= bus.DIR ? '0 : MAX_Q;
                    end
                end else begin
                    tc <= 1'b0;
                    q  <= bus.DIR ? (q + WIDTH'(1)) : (q - WIDTH'(1));
                end
            end else begin
                tc <= 1'b0;
            end
        end
    end

    assign bus.Q   = q;
    assign bus.TC  = tc;
    assign bus.OVF = ovf;

`ifdef MOD_STEP_COUNTER_HEX_EN
    logic [3:0] nib;
    logic [6:0] hex;

    if (WIDTH >= 4) begin : g_nib_wide
        assign nib = q[3:0];
    end else begin : g_nib_narrow
        assign nib = 4'(q);
    end

    // Active-low {g,f,e,d,c,b,a} hexadecimal digit decode of the low nibble.
    always_comb begin
        hex = 7'b1111111;
        case (nib)
            4'h0: hex = 7'b1000000;
            4'h1: hex = 7'b1111001;
            4'h2: hex = 7'b0100100;
            4'h3: hex = 7'b0110000;
            4'h4: hex = 7'b0011001;
            4'h5: hex = 7'b0010010;
            4'h6: hex = 7'b0000010;
            4'h7: hex = 7'b1111000;
            4'h8: hex = 7'b0000000;
            4'h9: hex = 7'b0010000;
            4'hA: hex = 7'b0001000;
            4'hB: hex = 7'b0000011;
            4'hC: hex = 7'b1000110;
            4'hD: hex = 7'b0100001;
            4'hE: hex = 7'b0000110;
            4'hF: hex = 7'b0001110;
            default: hex = 7'b1111111;
        endcase
    end

    assign bus.HEX = hex;
`endif

endmodule
